// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, buffer depth,
// the {instr, pc} entry layout and a PC alignment helper.
package instr_fetch_unit_pkg;

    localparam int unsigned InstrWidth = 32;
    localparam int unsigned PcWidth    = 32;
    localparam int unsigned Depth      = 2;

    // Buffer entry layout, MSB first: {instr, pc}
    localparam int unsigned EntryWidth = InstrWidth + PcWidth;

    // Instructions are word aligned; any set bit in pc[1:0] is a misaligned fetch
    function automatic logic is_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bus: PC handshake, instruction memory port and decode handshake.
// The slave modport is the fetch unit; the master modport is its environment.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned N_bit   = PcWidth,
    parameter int unsigned W_instr = InstrWidth
) ();

    logic [N_bit-1:0]   pc_in;
    logic               pc_valid;
    logic               pc_ready;
    logic               flush;
    logic               imem_rd_en;
    logic [N_bit-1:0]   imem_addr;
    logic [W_instr-1:0] imem_rdata;
    logic [W_instr-1:0] instr_out;
    logic [N_bit-1:0]   instr_pc;
    logic               instr_misalign;
    logic               instr_valid;
    logic               instr_ready;

    modport slave (
        input  pc_in, pc_valid, flush, imem_rdata, instr_ready,
        output pc_ready, imem_rd_en, imem_addr, instr_out, instr_pc, instr_misalign,
               instr_valid
    );

    modport master (
        output pc_in, pc_valid, flush, imem_rdata, instr_ready,
        input  pc_ready, imem_rd_en, imem_addr, instr_out, instr_pc, instr_misalign,
               instr_valid
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// In-order instruction buffer: register array with wrapping pointers, an occupancy
// count and a synchronous clear that dominates push/pop.
module instr_fetch_unit_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned Entries = Depth,
    parameter int unsigned Width   = EntryWidth
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        push,
    input  logic [Width-1:0]            push_data,
    input  logic                        pop,
    output logic [Width-1:0]            head_data,
    output logic [$clog2(Entries):0]    count
);

    localparam int unsigned PtrW = $clog2(Entries);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Entries];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Storage: write at the tail; reset to zero so outputs read 0 during reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Entries; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and count; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: accepts a PC, issues a 1-cycle-latency instruction memory read and
// buffers the returned word with its PC for decode. flush drops buffered and in-flight work.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned N_bit   = PcWidth,
    parameter int unsigned W_instr = InstrWidth,
    parameter int unsigned DEPTH   = Depth
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_unit_if.slave bus
);

    localparam int unsigned CntW   = $clog2(DEPTH) + 1;
    localparam int unsigned EntryW = W_instr + N_bit;

    logic              inflight_q;
    logic [N_bit-1:0]  pc_hold_q;
    logic              pop;
    logic              accept;
    logic              push;
    logic [CntW-1:0]   count;
    logic [CntW:0]     occupancy;
    logic [EntryW-1:0] head;

    assign bus.instr_valid = (count != '0);
    assign pop             = bus.instr_valid & bus.instr_ready;

    // Every in-flight read owns a slot; a same-cycle pop frees one for back-to-back fetch
    assign occupancy = {1'b0, count} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};
    assign bus.pc_ready = !reset && !bus.flush && (occupancy < (CntW + 1)'(DEPTH));

    assign accept         = bus.pc_valid & bus.pc_ready;
    assign bus.imem_rd_en = accept;
    assign bus.imem_addr  = bus.pc_in;

    // A response arriving in a flush cycle belongs to the discarded path
    assign push = inflight_q & ~bus.flush;

    assign bus.instr_out      = head[EntryW-1:N_bit];
    assign bus.instr_pc       = head[N_bit-1:0];
    assign bus.instr_misalign = is_misaligned(head[1:0]);

    // Track the outstanding read and remember its PC for tagging the response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q <= 1'b0;
            pc_hold_q  <= '0;
        end else begin
            inflight_q <= accept;
            if (accept) pc_hold_q <= bus.pc_in;
        end
    end

    instr_fetch_unit_fifo #(
        .Entries (DEPTH),
        .Width   (EntryW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.flush),
        .push      (push),
        .push_data ({bus.imem_rdata, pc_hold_q}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory model returns addr + 0x1000 one cycle
// after each read strobe.
module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    instr_fetch_unit_if bif ();

    instr_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory model
    always @(posedge clk) begin
        if (bif.imem_rd_en) bif.imem_rdata <= bif.imem_addr + 32'h1000;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        // Held in reset with a valid PC presented
        bif.pc_valid = 1'b1;
        bif.pc_in    = 32'h10;
        #2;
        n_cmp++; if (bif.pc_ready !== 1'b0) begin n_err++; $display("FAIL rst_pc_ready: got %b exp 0", bif.pc_ready); end
        n_cmp++; if (bif.imem_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b exp 0", bif.imem_rd_en); end
        n_cmp++; if (bif.imem_addr !== 32'h10) begin n_err++; $display("FAIL rst_addr: got %h exp 00000010", bif.imem_addr); end
        n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", bif.instr_valid); end
        tick;
        reset        = 1'b0;
        bif.pc_valid = 1'b0;
        #1;
        n_cmp++; if (bif.pc_ready !== 1'b1) begin n_err++; $display("FAIL rel_pc_ready: got %b exp 1", bif.pc_ready); end
        // Fill buffer to two entries with decode stalled
        bif.pc_valid = 1'b1;
        bif.pc_in    = 32'h100;
        tick;
        bif.pc_in = 32'h104;
        tick;
        n_cmp++; if (bif.pc_ready !== 1'b0) begin n_err++; $display("FAIL fill_pc_ready: got %b exp 0", bif.pc_ready); end
        tick;
        n_cmp++; if (bif.instr_pc !== 32'h100) begin n_err++; $display("FAIL fill_head_pc: got %h exp 00000100", bif.instr_pc); end
        // Asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b exp 0", bif.instr_valid); end
        n_cmp++; if (bif.imem_rd_en !== 1'b0) begin n_err++; $display("FAIL async_rd_en: got %b exp 0", bif.imem_rd_en); end
        n_cmp++; if (bif.instr_out !== 32'h0) begin n_err++; $display("FAIL async_instr: got %h exp 00000000", bif.instr_out); end
        n_cmp++; if (bif.instr_pc !== 32'h0) begin n_err++; $display("FAIL async_pc: got %h exp 00000000", bif.instr_pc); end
        n_cmp++; if (bif.imem_addr !== 32'h104) begin n_err++; $display("FAIL async_addr: got %h exp 00000104", bif.imem_addr); end
        tick;
        reset        = 1'b0;
        bif.pc_valid = 1'b0;
        #1;
        n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %b exp 0", bif.instr_valid); end
        n_cmp++; if (bif.pc_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b exp 1", bif.pc_ready); end
    endtask

    task automatic test_streaming;
        logic [31:0] exp_pc;
        bif.instr_ready = 1'b1;
        bif.pc_valid    = 1'b1;
        bif.pc_in       = 32'h0;
        for (int k = 0; k < 5; k++) begin
            tick;
            if (k < 3) bif.pc_in = 32'(4 * (k + 1));
            else bif.pc_valid = 1'b0;
            #1;
            if (k == 0) begin
                n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_first_valid: got %b exp 0", bif.instr_valid); end
            end else begin
                exp_pc = 32'(4 * (k - 1));
                n_cmp++; if (bif.instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid%0d: got %b exp 1", k, bif.instr_valid); end
                n_cmp++; if (bif.instr_out !== exp_pc + 32'h1000) begin n_err++; $display("FAIL stream_instr%0d: got %h exp %h", k, bif.instr_out, exp_pc + 32'h1000); end
                n_cmp++; if (bif.instr_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc%0d: got %h exp %h", k, bif.instr_pc, exp_pc); end
            end
            if (k < 3) begin
                n_cmp++; if (bif.pc_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready%0d: got %b exp 1", k, bif.pc_ready); end
            end
        end
        tick;
        n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_drained: got %b exp 0", bif.instr_valid); end
        bif.instr_ready = 1'b0;
    endtask

    task automatic test_back_pressure;
        bif.pc_valid = 1'b1;
        bif.pc_in    = 32'h20;
        #1;
        n_cmp++; if (bif.imem_rd_en !== 1'b1) begin n_err++; $display("FAIL bp_rd0: got %b exp 1", bif.imem_rd_en); end
        tick;
        bif.pc_in = 32'h24;
        #1;
        n_cmp++; if (bif.imem_rd_en !== 1'b1) begin n_err++; $display("FAIL bp_rd1: got %b exp 1", bif.imem_rd_en); end
        tick;
        bif.pc_in = 32'h28;
        #1;
        n_cmp++; if (bif.imem_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd2: got %b exp 0", bif.imem_rd_en); end
        tick;
        tick;
        n_cmp++; if (bif.pc_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready: got %b exp 0", bif.pc_ready); end
        n_cmp++; if (bif.instr_pc !== 32'h20) begin n_err++; $display("FAIL bp_stall_head: got %h exp 00000020", bif.instr_pc); end
        bif.instr_ready = 1'b1;
        #1;
        n_cmp++; if (bif.pc_ready !== 1'b1) begin n_err++; $display("FAIL bp_resume_ready: got %b exp 1", bif.pc_ready); end
        n_cmp++; if (bif.imem_addr !== 32'h28) begin n_err++; $display("FAIL bp_resume_addr: got %h exp 00000028", bif.imem_addr); end
        n_cmp++; if (bif.instr_out !== 32'h1020) begin n_err++; $display("FAIL bp_out0: got %h exp 00001020", bif.instr_out); end
        tick;
        bif.pc_valid = 1'b0;
        #1;
        n_cmp++; if (bif.instr_out !== 32'h1024) begin n_err++; $display("FAIL bp_out1: got %h exp 00001024", bif.instr_out); end
        tick;
        n_cmp++; if (bif.instr_out !== 32'h1028) begin n_err++; $display("FAIL bp_out2: got %h exp 00001028", bif.instr_out); end
        n_cmp++; if (bif.instr_pc !== 32'h28) begin n_err++; $display("FAIL bp_pc2: got %h exp 00000028", bif.instr_pc); end
        tick;
        n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b exp 0", bif.instr_valid); end
        bif.instr_ready = 1'b0;
    endtask

    task automatic test_flush;
        bif.pc_valid = 1'b1;
        bif.pc_in    = 32'h3C;
        tick;
        bif.pc_in = 32'h40;
        tick;
        bif.pc_valid = 1'b0;
        bif.flush    = 1'b1;
        #1;
        n_cmp++; if (bif.instr_valid !== 1'b1) begin n_err++; $display("FAIL fl_pre_valid: got %b exp 1", bif.instr_valid); end
        n_cmp++; if (bif.pc_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready: got %b exp 0", bif.pc_ready); end
        tick;
        bif.flush = 1'b0;
        #1;
        n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL fl_post_valid: got %b exp 0", bif.instr_valid); end
        tick;
        n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL fl_no_late: got %b exp 0", bif.instr_valid); end
        bif.pc_valid    = 1'b1;
        bif.pc_in       = 32'h80;
        bif.instr_ready = 1'b1;
        tick;
        bif.pc_valid = 1'b0;
        tick;
        n_cmp++; if (bif.instr_out !== 32'h1080) begin n_err++; $display("FAIL fl_next_instr: got %h exp 00001080", bif.instr_out); end
        n_cmp++; if (bif.instr_pc !== 32'h80) begin n_err++; $display("FAIL fl_next_pc: got %h exp 00000080", bif.instr_pc); end
        tick;
        n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL fl_drained: got %b exp 0", bif.instr_valid); end
        bif.instr_ready = 1'b0;
    endtask

    task automatic test_flush_with_valid;
        bif.flush    = 1'b1;
        bif.pc_valid = 1'b1;
        bif.pc_in    = 32'h90;
        #1;
        n_cmp++; if (bif.pc_ready !== 1'b0) begin n_err++; $display("FAIL fv_ready: got %b exp 0", bif.pc_ready); end
        n_cmp++; if (bif.imem_rd_en !== 1'b0) begin n_err++; $display("FAIL fv_rd_en: got %b exp 0", bif.imem_rd_en); end
        tick;
        bif.flush = 1'b0;
        #1;
        n_cmp++; if (bif.imem_rd_en !== 1'b1) begin n_err++; $display("FAIL fv_next_rd_en: got %b exp 1", bif.imem_rd_en); end
        tick;
        bif.pc_valid = 1'b0;
        tick;
        n_cmp++; if (bif.instr_out !== 32'h1090) begin n_err++; $display("FAIL fv_instr: got %h exp 00001090", bif.instr_out); end
        n_cmp++; if (bif.instr_pc !== 32'h90) begin n_err++; $display("FAIL fv_pc: got %h exp 00000090", bif.instr_pc); end
        bif.instr_ready = 1'b1;
        tick;
        n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL fv_drained: got %b exp 0", bif.instr_valid); end
    endtask

    task automatic test_misalign;
        bif.instr_ready = 1'b1;
        bif.pc_valid    = 1'b1;
        bif.pc_in       = 32'h6;
        tick;
        bif.pc_in = 32'h8;
        tick;
        bif.pc_valid = 1'b0;
        #1;
        n_cmp++; if (bif.instr_pc !== 32'h6) begin n_err++; $display("FAIL mis_pc: got %h exp 00000006", bif.instr_pc); end
        n_cmp++; if (bif.instr_out !== 32'h1006) begin n_err++; $display("FAIL mis_instr: got %h exp 00001006", bif.instr_out); end
        n_cmp++; if (bif.instr_misalign !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b exp 1", bif.instr_misalign); end
        tick;
        n_cmp++; if (bif.instr_pc !== 32'h8) begin n_err++; $display("FAIL al_pc: got %h exp 00000008", bif.instr_pc); end
        n_cmp++; if (bif.instr_misalign !== 1'b0) begin n_err++; $display("FAIL al_flag: got %b exp 0", bif.instr_misalign); end
        tick;
        n_cmp++; if (bif.instr_valid !== 1'b0) begin n_err++; $display("FAIL mis_drained: got %b exp 0", bif.instr_valid); end
        bif.instr_ready = 1'b0;
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        reset           = 1'b1;
        bif.pc_in       = '0;
        bif.pc_valid    = 1'b0;
        bif.flush       = 1'b0;
        bif.instr_ready = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_flush_with_valid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
